// File: rtl/jk_mod_counter_if.sv
// Control and status bundle for jk_mod_counter: the master drives count
// controls and load data, the slave returns the count and cascade pulses.
interface jk_mod_counter_if #(
    parameter int WIDTH = 4
);
    logic             EN;
    logic             UP;
    logic             LOAD;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] Q;
    logic             TC;
    logic             WRAP;
    logic             LOAD_ERR;

    modport master (
        output EN, UP, LOAD, D,
        input  Q, TC, WRAP, LOAD_ERR
    );

    modport slave (
        input  EN, UP, LOAD, D,
        output Q, TC, WRAP, LOAD_ERR
    );
endinterface

// File: rtl/jk_mod_counter.sv
// Single-clock modulo-MODULUS up/down counter where every bit is a JK stage;
// counting uses toggle terms (J=K), wrap and load use explicit set/reset terms.
module jk_mod_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic              CLK,
    input  logic              CLR,
    jk_mod_counter_if.slave   bus
);

    if (WIDTH < 1 || WIDTH > 16 || MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_param
        $error("jk_mod_counter: WIDTH must be 1..16 and MODULUS 2..2**WIDTH");
    end

    localparam logic [WIDTH-1:0] MAX     = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic [WIDTH-1:0] t;
    logic             carry;
    logic             at_max;
    logic             at_zero;
    logic             wrap_q;
    logic             wrap_nxt;
    logic             err_q;
    logic             err_nxt;

    assign at_max  = (q == MAX);
    assign at_zero = (q == '0);

    always_comb begin
        j        = '0;
        k        = '0;
        t        = '0;
        carry    = 1'b1;
        wrap_nxt = 1'b0;
        err_nxt  = 1'b0;
        if (bus.LOAD) begin
            if ({1'b0, bus.D} < MOD_EXT) begin
                j = bus.D;
                k = ~bus.D;
            end else begin
                k       = '1;
                err_nxt = 1'b1;
            end
        end else if (bus.EN) begin
            if (bus.UP && at_max) begin
                k        = '1;
                wrap_nxt = 1'b1;
            end else if (!bus.UP && at_zero) begin
                j        = MAX;
                k        = ~MAX;
                wrap_nxt = 1'b1;
            end else begin
                // A bit toggles when every lower bit is 1 (up) or 0 (down).
                for (int i = 0; i < WIDTH; i++) begin
                    t[i]  = carry;
                    carry = carry & (bus.UP ? q[i] : ~q[i]);
                end
                j = t;
                k = t;
            end
        end
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            q      <= '0;
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            q      <= (j & ~q) | (~k & q);
            wrap_q <= wrap_nxt;
            err_q  <= err_nxt;
        end
    end

    assign bus.Q        = q;
    assign bus.WRAP     = wrap_q;
    assign bus.LOAD_ERR = err_q;
    assign bus.TC       = bus.EN & ~bus.LOAD & (bus.UP ? at_max : at_zero);

endmodule

// File: tb/tb_jk_mod_counter.sv
// Directed bench for jk_mod_counter: vector table on a mod-10 counter, then
// async clear, a 1-bit degenerate counter and a two-digit cascade.
module tb_jk_mod_counter;

    logic CLK;
    logic CLR;
    int   checks;
    int   errors;

    jk_mod_counter_if #(.WIDTH(4)) m_if ();
    jk_mod_counter_if #(.WIDTH(1)) b_if ();
    jk_mod_counter_if #(.WIDTH(4)) u_if ();
    jk_mod_counter_if #(.WIDTH(4)) t_if ();

    jk_mod_counter #(.WIDTH(4), .MODULUS(10)) u_main  (.CLK(CLK), .CLR(CLR), .bus(m_if));
    jk_mod_counter #(.WIDTH(1), .MODULUS(2))  u_bit1  (.CLK(CLK), .CLR(CLR), .bus(b_if));
    jk_mod_counter #(.WIDTH(4), .MODULUS(10)) u_units (.CLK(CLK), .CLR(CLR), .bus(u_if));
    jk_mod_counter #(.WIDTH(4), .MODULUS(10)) u_tens  (.CLK(CLK), .CLR(CLR), .bus(t_if));

    assign t_if.EN = u_if.TC;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        string      name;
        logic       ld;
        logic       en;
        logic       up;
        logic [3:0] d;
        logic       tc;
        logic [3:0] q;
        logic       wr;
        logic       er;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string n, input logic ld, input logic en, input logic up,
                                input logic [3:0] d, input logic tc, input logic [3:0] q,
                                input logic wr, input logic er);
        vec_t v;
        v.name = n; v.ld = ld; v.en = en; v.up = up; v.d = d;
        v.tc = tc; v.q = q; v.wr = wr; v.er = er;
        return v;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse_clr();
        #2 CLR = 1'b1;
        #2 CLR = 1'b0;
    endtask

    initial begin
        int units_wraps;
        int tens_wraps;
        checks = 0;
        errors = 0;
        CLR = 1'b1;
        m_if.EN = 1'b0; m_if.UP = 1'b1; m_if.LOAD = 1'b0; m_if.D = '0;
        b_if.EN = 1'b0; b_if.UP = 1'b1; b_if.LOAD = 1'b0; b_if.D = '0;
        u_if.EN = 1'b0; u_if.UP = 1'b1; u_if.LOAD = 1'b0; u_if.D = '0;
        t_if.UP = 1'b1; t_if.LOAD = 1'b0; t_if.D = '0;

        // name, LOAD, EN, UP, D | TC before edge, Q, WRAP, LOAD_ERR after edge
        vecs.push_back(mk("up_0",    0, 1, 1, 0,  0, 1, 0, 0));
        vecs.push_back(mk("up_1",    0, 1, 1, 0,  0, 2, 0, 0));
        vecs.push_back(mk("up_2",    0, 1, 1, 0,  0, 3, 0, 0));
        vecs.push_back(mk("up_3",    0, 1, 1, 0,  0, 4, 0, 0));
        vecs.push_back(mk("up_4",    0, 1, 1, 0,  0, 5, 0, 0));
        vecs.push_back(mk("up_5",    0, 1, 1, 0,  0, 6, 0, 0));
        vecs.push_back(mk("up_6",    0, 1, 1, 0,  0, 7, 0, 0));
        vecs.push_back(mk("up_7",    0, 1, 1, 0,  0, 8, 0, 0));
        vecs.push_back(mk("up_8",    0, 1, 1, 0,  0, 9, 0, 0));
        vecs.push_back(mk("up_9",    0, 1, 1, 0,  1, 0, 1, 0));
        vecs.push_back(mk("up_0b",   0, 1, 1, 0,  0, 1, 0, 0));
        vecs.push_back(mk("up_1b",   0, 1, 1, 0,  0, 2, 0, 0));
        vecs.push_back(mk("ld_3",    1, 0, 0, 3,  0, 3, 0, 0));
        vecs.push_back(mk("dn_3",    0, 1, 0, 0,  0, 2, 0, 0));
        vecs.push_back(mk("dn_2",    0, 1, 0, 0,  0, 1, 0, 0));
        vecs.push_back(mk("dn_1",    0, 1, 0, 0,  0, 0, 0, 0));
        vecs.push_back(mk("dn_0",    0, 1, 0, 0,  1, 9, 1, 0));
        vecs.push_back(mk("dn_9",    0, 1, 0, 0,  0, 8, 0, 0));
        vecs.push_back(mk("ld_12",   1, 0, 0, 12, 0, 0, 0, 1));
        vecs.push_back(mk("ld_7",    1, 0, 0, 7,  0, 7, 0, 0));
        vecs.push_back(mk("hold_7",  0, 0, 1, 0,  0, 7, 0, 0));
        vecs.push_back(mk("ld_10",   1, 0, 1, 10, 0, 0, 0, 1));
        vecs.push_back(mk("ld_15",   1, 0, 1, 15, 0, 0, 0, 1));
        vecs.push_back(mk("ld_9",    1, 0, 1, 9,  0, 9, 0, 0));
        vecs.push_back(mk("hold_9",  0, 0, 1, 0,  0, 9, 0, 0));
        vecs.push_back(mk("lden_9",  1, 1, 1, 4,  0, 4, 0, 0));
        vecs.push_back(mk("ld_8",    1, 0, 1, 8,  0, 8, 0, 0));
        vecs.push_back(mk("lden_8",  1, 1, 1, 5,  0, 5, 0, 0));
        vecs.push_back(mk("hold_a",  0, 0, 1, 0,  0, 5, 0, 0));
        vecs.push_back(mk("hold_b",  0, 0, 0, 0,  0, 5, 0, 0));
        vecs.push_back(mk("hold_c",  0, 0, 1, 0,  0, 5, 0, 0));
        vecs.push_back(mk("hold_d",  0, 0, 0, 0,  0, 5, 0, 0));
        vecs.push_back(mk("dir_up",  0, 1, 1, 0,  0, 6, 0, 0));
        vecs.push_back(mk("dir_dn",  0, 1, 0, 0,  0, 5, 0, 0));
        vecs.push_back(mk("dir_dn2", 0, 1, 0, 0,  0, 4, 0, 0));

        // Reset is asynchronous: outputs must be clear before any clock edge.
        #2;
        check("rst_q",    16'(m_if.Q), 16'd0);
        check("rst_wrap", 16'(m_if.WRAP), 16'd0);
        check("rst_err",  16'(m_if.LOAD_ERR), 16'd0);
        step();
        #2 CLR = 1'b0;

        foreach (vecs[i]) begin
            m_if.LOAD = vecs[i].ld;
            m_if.EN   = vecs[i].en;
            m_if.UP   = vecs[i].up;
            m_if.D    = vecs[i].d;
            #1;
            check({vecs[i].name, "_tc"}, 16'(m_if.TC), 16'(vecs[i].tc));
            step();
            check({vecs[i].name, "_q"},    16'(m_if.Q), 16'(vecs[i].q));
            check({vecs[i].name, "_wrap"}, 16'(m_if.WRAP), 16'(vecs[i].wr));
            check({vecs[i].name, "_err"},  16'(m_if.LOAD_ERR), 16'(vecs[i].er));
        end

        // Mid-cycle clear at Q=6, held across an edge with LOAD pending.
        m_if.EN = 1'b0; m_if.LOAD = 1'b1; m_if.D = 4'd6;
        step();
        check("pre_clr_q", 16'(m_if.Q), 16'd6);
        m_if.D = 4'd5;
        #3 CLR = 1'b1;
        #1;
        check("clr_q",    16'(m_if.Q), 16'd0);
        check("clr_wrap", 16'(m_if.WRAP), 16'd0);
        check("clr_err",  16'(m_if.LOAD_ERR), 16'd0);
        step();
        check("clr_dom_q", 16'(m_if.Q), 16'd0);
        CLR = 1'b0;
        m_if.LOAD = 1'b0; m_if.EN = 1'b1; m_if.UP = 1'b1;
        step();
        check("resume_1", 16'(m_if.Q), 16'd1);
        step();
        check("resume_2", 16'(m_if.Q), 16'd2);

        // Clear must also kill a LOAD_ERR pulse in flight.
        m_if.LOAD = 1'b1; m_if.D = 4'd12;
        step();
        check("err_pulse", 16'(m_if.LOAD_ERR), 16'd1);
        pulse_clr();
        check("clr_err2", 16'(m_if.LOAD_ERR), 16'd0);
        m_if.LOAD = 1'b0; m_if.EN = 1'b0;

        // 1-bit counter: a plain toggle stage.
        pulse_clr();
        b_if.EN = 1'b1; b_if.UP = 1'b1;
        step();
        check("b1_q1",    16'(b_if.Q), 16'd1);
        check("b1_wrap1", 16'(b_if.WRAP), 16'd0);
        #1;
        check("b1_tc_up", 16'(b_if.TC), 16'd1);
        step();
        check("b1_q0",    16'(b_if.Q), 16'd0);
        check("b1_wrap0", 16'(b_if.WRAP), 16'd1);
        b_if.UP = 1'b0;
        #1;
        check("b1_tc_dn", 16'(b_if.TC), 16'd1);
        step();
        check("b1_dn_q",    16'(b_if.Q), 16'd1);
        check("b1_dn_wrap", 16'(b_if.WRAP), 16'd1);
        b_if.EN = 1'b0;

        // Two-digit cascade: tens advance on the units terminal count.
        pulse_clr();
        u_if.EN = 1'b1;
        units_wraps = 0;
        tens_wraps  = 0;
        for (int i = 1; i <= 105; i++) begin
            step();
            if (u_if.WRAP) units_wraps++;
            if (t_if.WRAP) tens_wraps++;
            if (i == 99) begin
                check("casc99_units", 16'(u_if.Q), 16'd9);
                check("casc99_tens",  16'(t_if.Q), 16'd9);
                check("casc99_tc",    16'(t_if.TC), 16'd1);
            end
        end
        check("casc_units",       16'(u_if.Q), 16'd5);
        check("casc_tens",        16'(t_if.Q), 16'd0);
        check("casc_units_wraps", 16'(units_wraps), 16'd10);
        check("casc_tens_wraps",  16'(tens_wraps), 16'd1);
        u_if.EN = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
